// File: rtl/vmicro16_cluster_cache_apb_if.sv
// APB bus bundle used on both sides of the cluster cache.
// The slave modport faces the cluster interconnect and the master modport faces the SoC IC_DMEM path.
interface vmicro16_cluster_cache_apb_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]  paddr;
  logic                  pwrite;
  logic                  pselx;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output paddr, pwrite, pselx, penable, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwrite, pselx, penable, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/vmicro16_cluster_cache_apb.sv
// Direct-mapped, write-through cluster data cache: read hits answer with zero wait states, everything else becomes one APB transfer.
// Define VMICRO16_CLUSTER_CACHE_STATS_EN to build the saturating hit/miss counters; otherwise stat_* are tied to zero.
module vmicro16_cluster_cache_apb #(
  parameter int BUS_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int CACHE_WORDS = 64,
  parameter int NOCACHE_BIT = 15
) (
  input  logic                                clk,
  input  logic                                reset,
  vmicro16_cluster_cache_apb_if.slave         s_apb,
  vmicro16_cluster_cache_apb_if.master        m_apb,
  input  logic                                flush,
  output logic [15:0]                         stat_hits,
  output logic [15:0]                         stat_miss
);
  localparam int IDX_W = $clog2(CACHE_WORDS);
  localparam int TAG_W = BUS_WIDTH - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, M_SETUP, M_ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [BUS_WIDTH-1:0]  addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CACHE_WORDS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_mem  [CACHE_WORDS];
  logic [DATA_WIDTH-1:0] data_mem [CACHE_WORDS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic cacheable, hit, read_hit, m_done, fill, write_update;
  logic start, count_hit, count_miss;

  assign idx          = addr_q[IDX_W-1:0];
  assign tag          = addr_q[BUS_WIDTH-1:IDX_W];
  assign cacheable    = ~addr_q[NOCACHE_BIT];
  assign hit          = cacheable & valid_q[idx] & (tag_mem[idx] == tag);
  assign read_hit     = hit & ~write_q;
  assign start        = (state_q == IDLE) & s_apb.pselx & ~s_apb.penable;
  assign m_done       = (state_q == M_ACCESS) & m_apb.pready;
  assign fill         = m_done & cacheable & ~write_q;
  assign write_update = m_done & write_q & hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    s_apb.pready  = 1'b0;
    s_apb.prdata  = '0;
    m_apb.pselx   = 1'b0;
    m_apb.penable = 1'b0;
    m_apb.paddr   = '0;
    m_apb.pwrite  = 1'b0;
    m_apb.pwdata  = '0;
    count_hit     = 1'b0;
    count_miss    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = LOOKUP;
      LOOKUP: begin
        if (read_hit) begin
          s_apb.pready = 1'b1;
          s_apb.prdata = data_mem[idx];
          count_hit    = 1'b1;
          state_d      = IDLE;
        end else begin
          count_miss = cacheable & ~write_q;
          state_d    = M_SETUP;
        end
      end
      M_SETUP, M_ACCESS: begin
        m_apb.pselx   = 1'b1;
        m_apb.penable = (state_q == M_ACCESS);
        m_apb.paddr   = addr_q;
        m_apb.pwrite  = write_q;
        m_apb.pwdata  = wdata_q;
        if (state_q == M_SETUP) state_d = M_ACCESS;
        else if (m_apb.pready)  state_d = RESP;
      end
      RESP: begin
        // A master that already abandoned the transfer gets no response.
        s_apb.pready = s_apb.pselx;
        s_apb.prdata = s_apb.pselx ? rdata_q : '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= s_apb.paddr;
        write_q <= s_apb.pwrite;
        wdata_q <= s_apb.pwdata;
      end
      if (m_done) rdata_q <= write_q ? '0 : m_apb.prdata;
      // Flush beats a coincident fill, leaving that line invalid.
      if (flush)     valid_q      <= '0;
      else if (fill) valid_q[idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= m_apb.prdata;
    end else if (write_update) begin
      data_mem[idx] <= wdata_q;
    end
  end

`ifdef VMICRO16_CLUSTER_CACHE_STATS_EN
  logic [15:0] hits_q, miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (flush) begin
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      if (count_hit  && hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
      if (count_miss && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  assign stat_hits = hits_q;
  assign stat_miss = miss_q;
`else
  logic unused_stats;
  assign unused_stats = count_hit ^ count_miss;
  assign stat_hits    = 16'h0000;
  assign stat_miss    = 16'h0000;
`endif
endmodule

// File: tb/tb_vmicro16_cluster_cache_apb.sv
// Bench for the cluster cache: an address-keyed line model predicts hit/miss, data, latency and statistics.
// A negedge monitor checks both APB sides every cycle; literal expectations pin the model.
module tb_vmicro16_cluster_cache_apb;
  localparam int CACHE_WORDS = 64;
`ifdef VMICRO16_CLUSTER_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] stat_hits, stat_miss;

  vmicro16_cluster_cache_apb_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) s_bus ();
  vmicro16_cluster_cache_apb_if #(.BUS_WIDTH(16), .DATA_WIDTH(16)) m_bus ();

  vmicro16_cluster_cache_apb #(
    .BUS_WIDTH(16), .DATA_WIDTH(16), .CACHE_WORDS(CACHE_WORDS), .NOCACHE_BIT(15)
  ) dut (
    .clk(clk), .reset(rst_n), .s_apb(s_bus), .m_apb(m_bus),
    .flush(flush), .stat_hits(stat_hits), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } line_t;

  line_t       model_lines [int];
  int          model_hits = 0;
  int          model_miss = 0;

  logic        txn_active = 1'b0;
  logic [15:0] exp_addr, exp_wdata, exp_rdata;
  logic        exp_write;
  int          m_setups;
  logic [15:0] soc_rdata = 16'h0;
  int          soc_waits = 0;
  bit          flush_arm = 1'b0;

  function automatic logic [15:0] exp_stat(input int cnt);
    return STATS ? 16'(cnt) : 16'h0000;
  endfunction

  // SoC-side responder: inserts soc_waits wait states, optionally fires a flush on the fill cycle.
  initial begin
    int  wcnt;
    bit  flushing;
    wcnt = 0;
    flushing = 1'b0;
    m_bus.pready = 1'b0;
    m_bus.prdata = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (flushing) begin
        flush    = 1'b0;
        flushing = 1'b0;
      end
      if (m_bus.pselx && m_bus.penable) begin
        if (flush_arm) begin
          flush     = 1'b1;
          flushing  = 1'b1;
          flush_arm = 1'b0;
        end
        if (wcnt >= soc_waits) begin
          m_bus.pready = 1'b1;
          m_bus.prdata = soc_rdata;
        end else begin
          wcnt++;
        end
      end else begin
        m_bus.pready = 1'b0;
        m_bus.prdata = 16'h0;
        wcnt = 0;
      end
    end
  end

  // Per-cycle monitor of both bus sides.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_m_pselx",   m_bus.pselx,   0);
      check("rst_m_penable", m_bus.penable, 0);
      check("rst_m_paddr",   m_bus.paddr,   0);
      check("rst_s_pready",  s_bus.pready,  0);
      check("rst_s_prdata",  s_bus.prdata,  0);
      check("rst_stat_hits", stat_hits,     0);
      check("rst_stat_miss", stat_miss,     0);
    end else begin
      if (m_bus.pselx) begin
        check("m_paddr",  m_bus.paddr,  exp_addr);
        check("m_pwrite", m_bus.pwrite, exp_write);
        check("m_pwdata", m_bus.pwdata, exp_wdata);
        if (!m_bus.penable) m_setups++;
      end else begin
        check("m_idle_penable", m_bus.penable, 0);
        check("m_idle_paddr",   m_bus.paddr,   0);
        check("m_idle_pwdata",  m_bus.pwdata,  0);
        check("m_idle_pwrite",  m_bus.pwrite,  0);
      end
      if (!txn_active)       check("s_pready_idle", s_bus.pready, 0);
      else if (s_bus.pready) check("s_prdata",      s_bus.prdata, exp_rdata);
    end
  end

  task automatic apb_xfer(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                          input logic [15:0] soc_data, input int waits, input bit flush_fill,
                          input bit lit_hit, input logic [15:0] lit_data);
    bit          cacheable, line_match, hit, done;
    int          idx, cycles;
    logic [15:0] exp_data, got;
    cacheable  = (addr < 16'h8000);
    idx        = int'(addr) % CACHE_WORDS;
    line_match = cacheable && model_lines.exists(idx) && model_lines[idx].addr == addr;
    hit        = line_match && !wr;
    exp_data   = hit ? model_lines[idx].data : (wr ? 16'h0 : soc_data);
    check("pin_hit",  hit,      lit_hit);
    check("pin_data", exp_data, lit_data);

    soc_rdata = soc_data;
    soc_waits = waits;
    flush_arm = flush_fill;
    exp_addr  = addr;
    exp_write = wr;
    exp_wdata = wdata;
    exp_rdata = exp_data;
    m_setups  = 0;
    got       = 16'hXXXX;

    @(posedge clk); #1;
    txn_active    = 1'b1;
    s_bus.paddr   = addr;
    s_bus.pwrite  = wr;
    s_bus.pwdata  = wdata;
    s_bus.pselx   = 1'b1;
    s_bus.penable = 1'b0;
    @(posedge clk); #1;
    s_bus.penable = 1'b1;
    cycles = 1;
    done   = 1'b0;
    while (!done && cycles <= 64) begin
      @(negedge clk);
      if (s_bus.pready) begin
        done = 1'b1;
        got  = s_bus.prdata;
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    check("xfer_timeout", done,   1);
    check("latency",      cycles, hit ? 1 : 4 + waits);
    check("rdata_lit",    got,    lit_data);
    @(posedge clk); #1;
    s_bus.pselx   = 1'b0;
    s_bus.penable = 1'b0;
    txn_active    = 1'b0;
    check("m_xfers", m_setups, hit ? 0 : 1);

    if (cacheable && !wr) begin
      if (hit) model_hits = (model_hits < 65535) ? model_hits + 1 : model_hits;
      else     model_miss = (model_miss < 65535) ? model_miss + 1 : model_miss;
    end
    if (wr && line_match) model_lines[idx].data = wdata;
    if (cacheable && !wr && !hit) model_lines[idx] = '{addr: addr, data: soc_data};
    if (flush_fill) begin
      model_lines.delete();
      model_hits = 0;
      model_miss = 0;
    end
    check("stat_hits", stat_hits, exp_stat(model_hits));
    check("stat_miss", stat_miss, exp_stat(model_miss));
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    model_lines.delete();
    model_hits = 0;
    model_miss = 0;
    check("flush_stat_hits", stat_hits, 0);
    check("flush_stat_miss", stat_miss, 0);
  endtask

  task automatic reset_mid_access();
    int cyc;
    soc_rdata = 16'hDEAD;
    soc_waits = 20;
    exp_addr  = 16'h0044;
    exp_write = 1'b0;
    exp_wdata = 16'h0;
    exp_rdata = 16'hDEAD;
    @(posedge clk); #1;
    txn_active    = 1'b1;
    s_bus.paddr   = 16'h0044;
    s_bus.pwrite  = 1'b0;
    s_bus.pwdata  = 16'h0;
    s_bus.pselx   = 1'b1;
    s_bus.penable = 1'b0;
    @(posedge clk); #1;
    s_bus.penable = 1'b1;
    cyc = 0;
    while (!(m_bus.pselx && m_bus.penable) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_m_access", m_bus.pselx && m_bus.penable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_pselx",   m_bus.pselx,   0);
    check("mid_rst_m_penable", m_bus.penable, 0);
    check("mid_rst_m_paddr",   m_bus.paddr,   0);
    check("mid_rst_s_pready",  s_bus.pready,  0);
    check("mid_rst_stat_miss", stat_miss,     0);
    model_lines.delete();
    model_hits = 0;
    model_miss = 0;
    @(posedge clk); #1;
    s_bus.pselx   = 1'b0;
    s_bus.penable = 1'b0;
    txn_active    = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    s_bus.paddr   = 16'h0;
    s_bus.pwrite  = 1'b0;
    s_bus.pselx   = 1'b0;
    s_bus.penable = 1'b0;
    s_bus.pwdata  = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_s_pready",  s_bus.pready, 0);
    check("reset_m_pselx",   m_bus.pselx,  0);
    check("reset_stat_hits", stat_hits,    0);
    check("reset_stat_miss", stat_miss,    0);

    // addr, wr, wdata, soc data, waits, flush on fill, literal hit, literal S_PRDATA
    apb_xfer(16'h0010, 0, 16'h0000, 16'hBEEF, 2, 0, 0, 16'hBEEF);
    apb_xfer(16'h0010, 0, 16'h0000, 16'h0BAD, 0, 0, 1, 16'hBEEF);
    apb_xfer(16'h0010, 1, 16'h1234, 16'h0BAD, 0, 0, 0, 16'h0000);
    apb_xfer(16'h0010, 0, 16'h0000, 16'h0BAD, 0, 0, 1, 16'h1234);
    apb_xfer(16'h0050, 0, 16'h0000, 16'hCAFE, 1, 0, 0, 16'hCAFE);
    apb_xfer(16'h0010, 0, 16'h0000, 16'h1111, 0, 0, 0, 16'h1111);
    apb_xfer(16'h8010, 0, 16'h0000, 16'h5555, 0, 0, 0, 16'h5555);
    apb_xfer(16'h8010, 0, 16'h0000, 16'h6666, 1, 0, 0, 16'h6666);
    apb_xfer(16'h0020, 1, 16'hAAAA, 16'h0BAD, 0, 0, 0, 16'h0000);
    apb_xfer(16'h0020, 0, 16'h0000, 16'h7777, 0, 0, 0, 16'h7777);
    apb_xfer(16'h0020, 0, 16'h0000, 16'h0BAD, 0, 0, 1, 16'h7777);
    pulse_flush();
    apb_xfer(16'h0010, 0, 16'h0000, 16'h2222, 0, 0, 0, 16'h2222);
    apb_xfer(16'h0030, 0, 16'h0000, 16'h3333, 0, 1, 0, 16'h3333);
    apb_xfer(16'h0030, 0, 16'h0000, 16'h4444, 0, 0, 0, 16'h4444);
    apb_xfer(16'h003F, 0, 16'h0000, 16'h9999, 3, 0, 0, 16'h9999);
    apb_xfer(16'h003F, 0, 16'h0000, 16'h0BAD, 0, 0, 1, 16'h9999);
    apb_xfer(16'h7FFF, 0, 16'h0000, 16'h8888, 0, 0, 0, 16'h8888);
    apb_xfer(16'h003F, 0, 16'h0000, 16'h7654, 0, 0, 0, 16'h7654);
    reset_mid_access();
    apb_xfer(16'h0010, 0, 16'h0000, 16'h1357, 0, 0, 0, 16'h1357);
    apb_xfer(16'h0010, 0, 16'h0000, 16'h0BAD, 0, 0, 1, 16'h1357);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
